mux_arb: RTL and testbench
==========================

# mux_arb

Two-input round-robin arbiter with a registered output stage that sequences the 2:1 byte mux. Two valid/ready sources (A and B) compete for one shared output channel. The arbiter chooses a winner each cycle and drives the mux select. The selected word is captured into a single output register, so downstream logic sees one clean, timed valid/ready stream instead of a raw combinational mux.

## Interface
Parameters:
- DATA_W, 8, width of each data word

Ports:
- clk  in  1  clock, all flops rising-edge
- reset_n  in  1  asynchronous, active-low reset
- a_valid_i  in  1  source A has a word
- a_data_i  in  DATA_W  source A word
- a_ready_o  out  1  A word accepted this cycle (combinational)
- b_valid_i  in  1  source B has a word
- b_data_i  in  DATA_W  source B word
- b_ready_o  out  1  B word accepted this cycle (combinational)
- y_valid_o  out  1  output register holds a word
- y_data_o  out  DATA_W  output word (registered)
- y_ready_i  in  1  sink accepts the output word
- sel_o  out  1  source of the word in the output register: 1 = A, 0 = B (registered)

## Operation
- Output FSM has two states:
  - EMPTY (y_valid_o=0)
  - FULL (y_valid_o=1)
- can_load = !y_valid_o | y_ready_i.
- Grant (combinational):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the source not recorded in last_a.
  - Neither valid: no grant.
- a_ready_o = can_load & grant A; b_ready_o = can_load & grant B. At most one ready is high in any cycle.
- Load, when a ready is high at the clock edge:
  - y_data_o ← the granted data.
  - sel_o ← the granted source.
  - y_valid_o ← 1.
  - last_a ← (granted source == A).
- Drain: FULL, y_ready_i=1 and no load → EMPTY, y_valid_o ← 0. y_data_o and sel_o hold their values.
- Simultaneous drain and load in FULL: remain FULL with the new word. This gives back-to-back throughput of one word per cycle.
- FULL with y_ready_i=0: y_data_o and sel_o are stable and both readies are 0, whatever the valids.
- last_a updates only on an accepted transfer. Idle cycles and stalls do not rotate priority.
- Sources must hold valid and data until ready; the arbiter does not check this.

## Timing
- Reset values:
  - y_valid_o=0
  - y_data_o=0
  - sel_o=1
  - last_a=0, so A wins the first contention.
- Latency: input accepted at edge N → y_valid_o/y_data_o visible after edge N.
- Ready paths depend combinationally on the input valids, y_valid_o and y_ready_i. There is no combinational path from data to ready.
- Reset asserted mid-transfer: the output register empties immediately and the held word is dropped. Priority returns to A.
- Under continuous contention and continuous y_ready_i=1, the output alternates A, B, A, B… one word per cycle.

## Configuration
- MUX_ARB_RR_EN defined: round-robin as described above.
- MUX_ARB_RR_EN not defined: fixed priority. A always wins when both sources are valid, and last_a is not implemented. All other behaviour is identical.

## Test plan
- Reset: hold reset_n=0 with both valids high → y_valid_o=0, y_data_o=0, sel_o=1, a_ready_o=b_ready_o=0. Release reset → A accepted first.
- Single source:
  - a_valid_i=1, a_data_i=8'hBA, y_ready_i=1 → next cycle y_data_o=8'hBA, sel_o=1.
  - Then only b_valid_i=1, b_data_i=8'h55 → y_data_o=8'h55, sel_o=0.
- Contention, RR build: A=8'h0F and B=8'h3F held valid, y_ready_i=1 → outputs 0F,3F,0F,3F on consecutive cycles.
- Contention, non-RR build: same stimulus → output 0F every cycle and b_ready_o stays 0.
- Back-pressure: load 8'hBA, then y_ready_i=0 for 3 cycles with B valid → y_data_o stays BA, both readies 0. Raise y_ready_i → 8'h55 follows on the next cycle with no bubble.
- Mid-reset: pulse reset_n low for half a cycle while FULL with 8'hBA → y_valid_o drops immediately, and the word does not reappear after release.

Source files
------------

// File: rtl/mux_arb_if.sv
// rtl/mux_arb_if.sv - Handshake bundle between two sources, the mux arbiter and its sink.
//
// Signals (directions as seen by the arbiter, modport slave):
//   a_valid_i / a_data_i / a_ready_o : source A word, accept strobe
//   b_valid_i / b_data_i / b_ready_o : source B word, accept strobe
//   y_valid_o / y_data_o / y_ready_i : registered output stream
//   sel_o                            : 1 = output word came from A, 0 = from B
// modport master is the opposite side (sources + sink).

interface mux_arb_if #(
    parameter int DATA_W = 8
);
    logic              a_valid_i;
    logic [DATA_W-1:0] a_data_i;
    logic              a_ready_o;
    logic              b_valid_i;
    logic [DATA_W-1:0] b_data_i;
    logic              b_ready_o;
    logic              y_valid_o;
    logic [DATA_W-1:0] y_data_o;
    logic              y_ready_i;
    logic              sel_o;

    modport slave (
        input  a_valid_i, a_data_i, b_valid_i, b_data_i, y_ready_i,
        output a_ready_o, b_ready_o, y_valid_o, y_data_o, sel_o
    );

    modport master (
        output a_valid_i, a_data_i, b_valid_i, b_data_i, y_ready_i,
        input  a_ready_o, b_ready_o, y_valid_o, y_data_o, sel_o
    );
endinterface

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - Two-input arbiter feeding a single registered output word.
//
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mux_arb_if.slave (A/B sources in, registered y stream out, sel_o)
// Parameter DATA_W : data word width.
// Build macro MUX_ARB_RR_EN : defined -> round-robin between A and B under
// contention; undefined -> A always wins contention.

module mux_arb #(
    parameter int DATA_W = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    mux_arb_if.slave bus
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state;
    logic [DATA_W-1:0] y_data_q;
    logic              sel_q;
    logic              can_load;
    logic              grant_a;
    logic              grant_b;
    logic              a_ready;
    logic              b_ready;
    logic              load;
`ifdef MUX_ARB_RR_EN
    logic              last_a;
`endif

    // The output register can take a word when empty or when the current
    // word leaves in the same cycle.
    assign can_load = (state == ST_EMPTY) || bus.y_ready_i;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (bus.a_valid_i && bus.b_valid_i) begin
`ifdef MUX_ARB_RR_EN
            grant_a = !last_a;
            grant_b = last_a;
`else
            grant_a = 1'b1;
`endif
        end else begin
            grant_a = bus.a_valid_i;
            grant_b = bus.b_valid_i;
        end
    end

    // Readies are held low while reset is asserted so nothing is taken
    // by a register that is being cleared.
    assign a_ready = reset_n && can_load && grant_a;
    assign b_ready = reset_n && can_load && grant_b;
    assign load    = a_ready || b_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_EMPTY;
            y_data_q <= '0;
            sel_q    <= 1'b1;
`ifdef MUX_ARB_RR_EN
            last_a   <= 1'b0;
`endif
        end else if (load) begin
            state    <= ST_FULL;
            y_data_q <= a_ready ? bus.a_data_i : bus.b_data_i;
            sel_q    <= a_ready;
`ifdef MUX_ARB_RR_EN
            last_a   <= a_ready;
`endif
        end else if (state == ST_FULL && bus.y_ready_i) begin
            // Drain only: data and sel keep their last values.
            state <= ST_EMPTY;
        end
    end

    assign bus.a_ready_o = a_ready;
    assign bus.b_ready_o = b_ready;
    assign bus.y_valid_o = (state == ST_FULL);
    assign bus.y_data_o  = y_data_q;
    assign bus.sel_o     = sel_q;
endmodule

// File: tb/tb_mux_arb.sv
// tb/tb_mux_arb.sv - Self-checking bench for mux_arb with a reference model.

module tb_mux_arb;
    logic clk = 1'b0;
    logic reset_n;
    int   n_pass = 0;
    int   n_total = 0;

    mux_arb_if #(.DATA_W(8)) bus ();

    mux_arb #(.DATA_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: contents of the output register plus the history of
    // which source won each accepted transfer.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_sel;
    logic       hist[$];
    logic       acc_a;
    logic       acc_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 1'b1;
        hist.delete();
    endtask

    // Under contention: fixed build always picks A; round-robin build picks
    // whichever source did not win the most recent accepted transfer.
    function automatic logic a_wins_contention();
`ifdef MUX_ARB_RR_EN
        if (hist.size() == 0) return 1'b1;
        return !hist[hist.size()-1];
`else
        return 1'b1;
`endif
    endfunction

    // Called right after a falling edge: drive, check, advance model, wait.
    task automatic step(input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd, input logic yr);
        logic ea, eb, room, win_a;
        bus.a_valid_i = av;
        bus.a_data_i  = ad;
        bus.b_valid_i = bv;
        bus.b_data_i  = bd;
        bus.y_ready_i = yr;
        #1;
        room  = !m_valid || yr;
        win_a = a_wins_contention();
        ea = room && av && (!bv || win_a);
        eb = room && bv && (!av || !win_a);
        check("a_ready", bus.a_ready_o, ea);
        check("b_ready", bus.b_ready_o, eb);
        check("y_valid", bus.y_valid_o, m_valid);
        if (m_valid) begin
            check("y_data", bus.y_data_o, m_data);
            check("sel", bus.sel_o, m_sel);
        end
        acc_a = ea;
        acc_b = eb;
        if (ea || eb) begin
            m_valid = 1'b1;
            m_data  = ea ? ad : bd;
            m_sel   = ea;
            hist.push_back(ea);
        end else if (m_valid && yr) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic       pa, pb;
        logic [7:0] da, db;
        logic [7:0] pat [4];

        reset_n = 1'b0;
        bus.a_valid_i = 1'b1;
        bus.a_data_i  = 8'h0F;
        bus.b_valid_i = 1'b1;
        bus.b_data_i  = 8'h3F;
        bus.y_ready_i = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_y_valid", bus.y_valid_o, 1'b0);
        check("rst_y_data", bus.y_data_o, 8'h00);
        check("rst_sel", bus.sel_o, 1'b1);
        check("rst_a_ready", bus.a_ready_o, 1'b0);
        check("rst_b_ready", bus.b_ready_o, 1'b0);
        reset_n = 1'b1;

        // Contention with continuous sink readiness.
`ifdef MUX_ARB_RR_EN
        pat = '{8'h0F, 8'h3F, 8'h0F, 8'h3F};
`else
        pat = '{8'h0F, 8'h0F, 8'h0F, 8'h0F};
`endif
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'h0F, 1'b1, 8'h3F, 1'b1);
            check($sformatf("contend%0d", i), bus.y_data_o, pat[i]);
        end
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        check("drain_valid", bus.y_valid_o, 1'b0);

        // Single sources.
        step(1'b1, 8'hBA, 1'b0, 8'h00, 1'b1);
        check("single_a_data", bus.y_data_o, 8'hBA);
        check("single_a_sel", bus.sel_o, 1'b1);
        step(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        check("single_b_data", bus.y_data_o, 8'h55);
        check("single_b_sel", bus.sel_o, 1'b0);

        // Back-pressure then release with no bubble.
        step(1'b1, 8'hBA, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
            check("stall_data", bus.y_data_o, 8'hBA);
        end
        step(1'b0, 8'h00, 1'b1, 8'h55, 1'b1);
        check("release_data", bus.y_data_o, 8'h55);
        check("release_valid", bus.y_valid_o, 1'b1);

        // Reset pulse while holding a word.
        step(1'b1, 8'hBA, 1'b0, 8'h00, 1'b1);
        check("pre_reset_data", bus.y_data_o, 8'hBA);
        bus.a_valid_i = 1'b0;
        bus.b_valid_i = 1'b0;
        bus.y_ready_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check("midrst_valid", bus.y_valid_o, 1'b0);
        check("midrst_data", bus.y_data_o, 8'h00);
        check("midrst_sel", bus.sel_o, 1'b1);
        #3;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        check("post_rst_valid", bus.y_valid_o, 1'b0);
        step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        check("post_rst_a_first", bus.y_data_o, 8'h11);

        // Randomized traffic; sources hold valid/data until accepted.
        pa = 1'b0; pb = 1'b0; da = 8'h00; db = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (!pa) begin
                pa = ($urandom_range(0, 9) < 7);
                da = 8'($urandom);
            end
            if (!pb) begin
                pb = ($urandom_range(0, 9) < 7);
                db = 8'($urandom);
            end
            step(pa, da, pb, db, 1'($urandom_range(0, 3) != 0));
            if (acc_a) pa = 1'b0;
            if (acc_b) pb = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
